// File: rtl/mdio_mem_reader_if.sv
// Capture-memory read port used by the MDIO read responder.
// The master side (the responder) issues the read strobe and address and
// receives the wide memory word.
interface mdio_mem_reader_if #(
  parameter int LANES  = 96,
  parameter int ADDR_W = 15
);
  logic                   mem_rd_en;
  logic [ADDR_W-1:0]      mem_addr;
  logic [LANES*9-1:0]     mem_rdata;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_rdata
  );
endinterface

// File: rtl/mdio_mem_reader.sv
// MDIO single-word read responder for the capture memory.
// Accepts a synchronised read request, issues one memory read, extracts the
// selected 9-bit lane and presents it with a one-cycle valid pulse. A guard
// gap after each pulse keeps the return handshake from being re-triggered
// before it has recovered; requests arriving while busy are dropped and
// flagged in a sticky overrun bit.
module mdio_mem_reader #(
  parameter int LANES       = 96,
  parameter int ADDR_W      = 15,
  parameter int MEM_LATENCY = 1,
  parameter int GAP_CYCLES  = 8
) (
  input  logic              pktctrl_clk,
  input  logic              pktctrl_rst,
  input  logic              rf_mdio_read_pulse_sync,
  input  logic [ADDR_W-1:0] rf_mdio_memory_addr_sync,
  input  logic [6:0]        rf_mdio_data_sel_sync,
  input  logic              rf_overrun_clr,
  mdio_mem_reader_if.master mem_bus,
  output logic [8:0]        rf_mdio_pkt_data,
  output logic              mdio_read_pulse_r,
  output logic              busy,
  output logic              rd_overrun,
  output logic [15:0]       rd_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SEL   = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Counter reload values; MEM_LATENCY-1 fits two bits for latencies 1..4.
  localparam logic [1:0] WAIT_LOAD = 2'(MEM_LATENCY - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES);

  state_t            state_q;
  logic              mem_rd_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [6:0]        sel_q;
  logic [1:0]        wait_cnt_q;
  logic [7:0]        gap_cnt_q;
  logic [8:0]        pkt_data_q;
  logic              pulse_q;
  logic              busy_q;
  logic              overrun_q;
  logic [15:0]       rd_cnt_q;
  logic [8:0]        lane_s;

  // Lane multiplexer: out-of-range selects yield all ones, never a slice past the word.
  always_comb begin
    lane_s = 9'h1FF;
    for (int k = 0; k < LANES; k++) begin
      lane_s = (sel_q == 7'(k)) ? mem_bus.mem_rdata[9*k +: 9] : lane_s;
    end
  end

  // Read sequencer: request accept, memory strobe, latency wait, result pulse, guard gap.
  always_ff @(posedge pktctrl_clk or posedge pktctrl_rst) begin
    if (pktctrl_rst) begin
      state_q     <= ST_IDLE;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      sel_q       <= 7'd0;
      wait_cnt_q  <= 2'd0;
      gap_cnt_q   <= 8'd0;
      pkt_data_q  <= 9'd0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      rd_cnt_q    <= 16'd0;
    end else begin
      mem_rd_en_q <= 1'b0;
      pulse_q     <= 1'b0;

      // A drop in the same cycle as a clear keeps the flag set.
      if (rf_mdio_read_pulse_sync && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end else if (rf_overrun_clr) begin
        overrun_q <= 1'b0;
      end else begin
        overrun_q <= overrun_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (rf_mdio_read_pulse_sync) begin
            mem_addr_q  <= rf_mdio_memory_addr_sync;
            sel_q       <= rf_mdio_data_sel_sync;
            mem_rd_en_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          wait_cnt_q <= WAIT_LOAD;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt_q == 2'd0) begin
            // This is the cycle mem_rdata is valid.
            pkt_data_q <= lane_s;
            pulse_q    <= 1'b1;
            state_q    <= ST_SEL;
          end else begin
            wait_cnt_q <= wait_cnt_q - 2'd1;
          end
        end
        ST_SEL: begin
          rd_cnt_q  <= rd_cnt_q + 16'd1;
          gap_cnt_q <= GAP_LOAD;
          if (GAP_CYCLES == 0) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          // Leaving on the last gap cycle makes IDLE visible exactly GAP_CYCLES after the pulse.
          if (gap_cnt_q <= 8'd1) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_bus.mem_rd_en = mem_rd_en_q;
  assign mem_bus.mem_addr  = mem_addr_q;
  assign rf_mdio_pkt_data  = pkt_data_q;
  assign mdio_read_pulse_r = pulse_q;
  assign busy              = busy_q;
  assign rd_overrun        = overrun_q;
  assign rd_cnt            = rd_cnt_q;

endmodule

// File: tb/tb_mdio_mem_reader.sv
// Self-checking bench for mdio_mem_reader: a default-parameter instance (A)
// and a MEM_LATENCY=3 / GAP_CYCLES=0 instance (B). Expected lane values are
// queued when a request is driven and compared when the result pulse appears.
module tb_mdio_mem_reader;

  localparam int LANES  = 96;
  localparam int ADDR_W = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [8:0] q_a[$];
  logic [8:0] q_b[$];

  // Instance A stimulus / observation
  logic              req_a = 1'b0;
  logic [ADDR_W-1:0] addr_a = '0;
  logic [6:0]        sel_a = 7'd0;
  logic              clr_a = 1'b0;
  logic [8:0]        data_a;
  logic              pulse_a, busy_a, ovr_a;
  logic [15:0]       cnt_a;
  logic [LANES*9-1:0] word_a = '0;
  logic              v_a = 1'b0;

  // Instance B stimulus / observation
  logic              req_b = 1'b0;
  logic [ADDR_W-1:0] addr_b = '0;
  logic [6:0]        sel_b = 7'd0;
  logic [8:0]        data_b;
  logic              pulse_b, busy_b, ovr_b;
  logic [15:0]       cnt_b;
  logic [LANES*9-1:0] word_b = '0;
  logic [2:0]        v_b = 3'b000;

  mdio_mem_reader_if #(.LANES(LANES), .ADDR_W(ADDR_W)) if_a ();
  mdio_mem_reader_if #(.LANES(LANES), .ADDR_W(ADDR_W)) if_b ();

  mdio_mem_reader #(.LANES(LANES), .ADDR_W(ADDR_W), .MEM_LATENCY(1), .GAP_CYCLES(8)) dut_a (
    .pktctrl_clk              (clk),
    .pktctrl_rst              (rst),
    .rf_mdio_read_pulse_sync  (req_a),
    .rf_mdio_memory_addr_sync (addr_a),
    .rf_mdio_data_sel_sync    (sel_a),
    .rf_overrun_clr           (clr_a),
    .mem_bus                  (if_a.master),
    .rf_mdio_pkt_data         (data_a),
    .mdio_read_pulse_r        (pulse_a),
    .busy                     (busy_a),
    .rd_overrun               (ovr_a),
    .rd_cnt                   (cnt_a)
  );

  mdio_mem_reader #(.LANES(LANES), .ADDR_W(ADDR_W), .MEM_LATENCY(3), .GAP_CYCLES(0)) dut_b (
    .pktctrl_clk              (clk),
    .pktctrl_rst              (rst),
    .rf_mdio_read_pulse_sync  (req_b),
    .rf_mdio_memory_addr_sync (addr_b),
    .rf_mdio_data_sel_sync    (sel_b),
    .rf_overrun_clr           (1'b0),
    .mem_bus                  (if_b.master),
    .rf_mdio_pkt_data         (data_b),
    .mdio_read_pulse_r        (pulse_b),
    .busy                     (busy_b),
    .rd_overrun               (ovr_b),
    .rd_cnt                   (cnt_b)
  );

  always #5 clk = ~clk;

  // Memory models: the word is valid exactly MEM_LATENCY cycles after the strobe,
  // and its complement is presented in every other cycle.
  always_ff @(posedge clk) begin
    v_a <= if_a.mem_rd_en;
    v_b <= {v_b[1:0], if_b.mem_rd_en};
  end
  assign if_a.mem_rdata = v_a    ? word_a : ~word_a;
  assign if_b.mem_rdata = v_b[2] ? word_b : ~word_b;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result monitors: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (pulse_a === 1'b1) begin
      if (q_a.size() == 0) check_val("a_unexpected_pulse", 32'd1, 32'd0);
      else check_val("a_sb_data", 32'(data_a), 32'(q_a.pop_front()));
    end
    if (pulse_b === 1'b1) begin
      if (q_b.size() == 0) check_val("b_unexpected_pulse", 32'd1, 32'd0);
      else check_val("b_sb_data", 32'(data_b), 32'(q_b.pop_front()));
    end
  end

  task automatic fill_a();
    for (int k = 0; k < LANES; k++) word_a[9*k +: 9] = 9'($urandom);
  endtask

  // One full read on A starting in cycle 0; returns in cycle 12 with A idle.
  task automatic read_a(input logic [ADDR_W-1:0] addr, input logic [6:0] sel, input logic [8:0] exp);
    req_a = 1'b1; addr_a = addr; sel_a = sel;
    q_a.push_back(exp);
    tick();                                          // cycle 1
    req_a = 1'b0;
    check_val("a_rden_c1", 32'(if_a.mem_rd_en), 32'd1);
    check_val("a_addr_c1", 32'(if_a.mem_addr), 32'(addr));
    tick();                                          // cycle 2
    check_val("a_rden_c2", 32'(if_a.mem_rd_en), 32'd0);
    check_val("a_pulse_c2", 32'(pulse_a), 32'd0);
    tick();                                          // cycle 3
    check_val("a_pulse_c3", 32'(pulse_a), 32'd1);
    check_val("a_data_c3", 32'(data_a), 32'(exp));
    tick();                                          // cycle 4
    check_val("a_pulse_c4", 32'(pulse_a), 32'd0);
    check_val("a_data_hold_c4", 32'(data_a), 32'(exp));
    repeat (7) tick();                               // cycle 11
    check_val("a_busy_c11", 32'(busy_a), 32'd1);
    tick();                                          // cycle 12
    check_val("a_busy_c12", 32'(busy_a), 32'd0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check_val("rst_rden", 32'(if_a.mem_rd_en), 32'd0);
    check_val("rst_addr", 32'(if_a.mem_addr), 32'd0);
    check_val("rst_data", 32'(data_a), 32'd0);
    check_val("rst_pulse", 32'(pulse_a), 32'd0);
    check_val("rst_busy", 32'(busy_a), 32'd0);
    check_val("rst_ovr", 32'(ovr_a), 32'd0);
    check_val("rst_cnt", 32'(cnt_a), 32'd0);
    rst = 1'b0;

    // B: latency 3, no gap, back-to-back requests every 6 cycles
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < LANES; k++) word_b[9*k +: 9] = 9'($urandom);
      word_b[9*(i*30) +: 9] = 9'(i*50 + 7);
      req_b = 1'b1; addr_b = 15'(16'h0100 + i); sel_b = 7'(i*30);
      q_b.push_back(9'(i*50 + 7));
      tick();                                        // cycle 1
      req_b = 1'b0;
      check_val("b_rden_c1", 32'(if_b.mem_rd_en), 32'd1);
      check_val("b_addr_c1", 32'(if_b.mem_addr), 32'(16'h0100 + i));
      repeat (3) tick();                             // cycle 4
      check_val("b_pulse_c4", 32'(pulse_b), 32'd0);
      tick();                                        // cycle 5
      check_val("b_pulse_c5", 32'(pulse_b), 32'd1);
      check_val("b_busy_c5", 32'(busy_b), 32'd1);
      tick();                                        // cycle 6
      check_val("b_busy_c6", 32'(busy_b), 32'd0);
    end
    repeat (6) tick();
    check_val("b_overrun", 32'(ovr_b), 32'd0);
    check_val("b_cnt", 32'(cnt_b), 32'd4);
    check_val("b_queue_empty", 32'(q_b.size()), 32'd0);

    // A: basic read
    fill_a();
    word_a[9*5 +: 9] = 9'h0A5;
    read_a(15'h1234, 7'd5, 9'h0A5);
    check_val("a_cnt_basic", 32'(cnt_a), 32'd1);

    // A: lane bounds
    fill_a(); word_a[0 +: 9] = 9'h101;
    read_a(15'h0001, 7'd0, 9'h101);
    fill_a(); word_a[9*95 +: 9] = 9'h0FE;
    read_a(15'h7FFF, 7'd95, 9'h0FE);
    fill_a();
    read_a(15'h0002, 7'd96, 9'h1FF);
    fill_a();
    read_a(15'h0003, 7'd127, 9'h1FF);
    check_val("a_cnt_bounds", 32'(cnt_a), 32'd5);

    // A: overrun -- drops at cycle 2 and during the gap
    fill_a(); word_a[9*17 +: 9] = 9'h033;
    req_a = 1'b1; addr_a = 15'h0444; sel_a = 7'd17;
    q_a.push_back(9'h033);
    tick(); req_a = 1'b0;                            // cycle 1
    tick(); req_a = 1'b1; sel_a = 7'd0;              // cycle 2: dropped
    tick(); req_a = 1'b0;                            // cycle 3
    check_val("ovr_pulse_c3", 32'(pulse_a), 32'd1);
    check_val("ovr_data_c3", 32'(data_a), 32'h033);
    check_val("ovr_flag_c3", 32'(ovr_a), 32'd1);
    repeat (3) tick(); req_a = 1'b1;                 // cycle 6: dropped in gap
    tick(); req_a = 1'b0;                            // cycle 7
    repeat (5) tick();                               // cycle 12
    check_val("ovr_busy_c12", 32'(busy_a), 32'd0);
    check_val("ovr_flag_end", 32'(ovr_a), 32'd1);
    check_val("ovr_cnt", 32'(cnt_a), 32'd6);
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    check_val("ovr_clr_idle", 32'(ovr_a), 32'd0);
    // clear together with a new drop: set wins
    fill_a(); word_a[9*3 +: 9] = 9'h0C3;
    req_a = 1'b1; addr_a = 15'h0555; sel_a = 7'd3;
    q_a.push_back(9'h0C3);
    tick(); req_a = 1'b0;                            // cycle 1
    tick(); req_a = 1'b1; clr_a = 1'b1;              // cycle 2
    tick(); req_a = 1'b0; clr_a = 1'b0;              // cycle 3
    check_val("ovr_set_wins", 32'(ovr_a), 32'd1);
    repeat (9) tick();                               // cycle 12
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    check_val("ovr_clr_alone", 32'(ovr_a), 32'd0);

    // A: reset during WAIT aborts the read
    fill_a();
    req_a = 1'b1; addr_a = 15'h0666; sel_a = 7'd9;
    tick(); req_a = 1'b0;                            // cycle 1 (ISSUE)
    tick();                                          // cycle 2 (WAIT)
    rst = 1'b1; #1;
    check_val("mid_rst_pulse", 32'(pulse_a), 32'd0);
    check_val("mid_rst_busy", 32'(busy_a), 32'd0);
    check_val("mid_rst_cnt", 32'(cnt_a), 32'd0);
    check_val("mid_rst_data", 32'(data_a), 32'd0);
    check_val("mid_rst_addr", 32'(if_a.mem_addr), 32'd0);
    tick(); tick();
    check_val("mid_rst_nopulse", 32'(pulse_a), 32'd0);
    rst = 1'b0;
    fill_a(); word_a[9*9 +: 9] = 9'h15A;
    read_a(15'h0777, 7'd9, 9'h15A);
    check_val("post_rst_cnt", 32'(cnt_a), 32'd1);

    // A: rd_cnt wraps from FFFF to 0
    force dut_a.rd_cnt_q = 16'hFFFF;
    tick();
    release dut_a.rd_cnt_q;
    check_val("wrap_preload", 32'(cnt_a), 32'hFFFF);
    fill_a(); word_a[9*40 +: 9] = 9'h0AA;
    read_a(15'h0888, 7'd40, 9'h0AA);
    check_val("wrap_cnt", 32'(cnt_a), 32'd0);

    repeat (3) tick();
    check_val("a_queue_empty", 32'(q_a.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
